// File: rtl/elbeth_dmem_responder.sv
`default_nettype none
// =============================================================================
// Module  : elbeth_dmem_responder
// Brief   : Memory end of an en/ready handshake. Single-port word memory with
//           wait states, byte-lane steering, read extension and alignment check.
// Revision: 1.0  initial release
// =============================================================================
module elbeth_dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_size,
   input  logic        mem_sign,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_error
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] BUSY     = 2'd1;
   localparam logic [1:0] ACK      = 2'd2;
   localparam int         DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            size_q, size_d;
   logic                  sign_q, sign_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  error_q, error_d;

   logic [31:0]           mem [DEPTH];

   logic                  access;
   logic                  bad;
   logic [1:0]            lane;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           shifted;
   logic [31:0]           rd_ext;
   logic [3:0]            wmask;
   logic [31:0]           wshift;
   logic                  unused_addr_bits;

   // High address bits only alias onto the array.
   assign unused_addr_bits = &{1'b0, mem_addr[31:ADDR_WIDTH+2]};

   assign lane    = addr_q[1:0];
   assign idx     = addr_q[ADDR_WIDTH+1:2];
   assign access  = (state_q == BUSY) && (cnt_q == 4'd0);
   assign shifted = mem[idx] >> {lane, 3'b000};
   assign wmask   = 4'(size_q << lane);
   assign wshift  = wdata_q << {lane, 3'b000};

   always_comb begin
      case (size_q)
         4'b0001: bad = 1'b0;
         4'b0011: bad = lane[0];
         4'b1111: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
   end

   always_comb begin
      case (size_q)
         4'b0001: rd_ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
         4'b0011: rd_ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
         default: rd_ext = shifted;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         size_q  <= 4'd0;
         sign_q  <= 1'b0;
         rdata_q <= 32'd0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   // Array is not reset; an async reset during BUSY clears state so the write never fires.
   always_ff @(posedge clk) begin
      if (access && we_q && !bad) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
         end
      end
   end

   // Next-state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (mem_en) begin
               state_d = BUSY;
               cnt_d   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = ACK;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ACK: begin
            if (!mem_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture and result outputs
   always_comb begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sign_d  = sign_q;
      rdata_d = rdata_q;
      error_d = error_q;
      if (state_q == IDLE && mem_en) begin
         we_d    = mem_we;
         addr_d  = mem_addr[ADDR_WIDTH+1:0];
         wdata_d = mem_wdata;
         size_d  = mem_size;
         sign_d  = mem_sign;
      end
      if (access) begin
         rdata_d = (bad || we_q) ? 32'd0 : rd_ext;
         error_d = bad;
      end
   end

   assign mem_ready = (state_q == ACK);
   assign mem_rdata = rdata_q;
   assign mem_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_elbeth_dmem_responder.sv
`default_nettype none
// =============================================================================
// Module  : tb_elbeth_dmem_responder
// Brief   : Directed self-checking bench with an expected-result scoreboard.
// Revision: 1.0  initial release
// =============================================================================
module tb_elbeth_dmem_responder;
   localparam int ADDR_WIDTH = 10;
   localparam int LATENCY    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en, mem_we, mem_sign;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_size;
   logic        mem_ready, mem_error;
   logic [31:0] mem_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] sb [$];

   elbeth_dmem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_size  (mem_size),
      .mem_sign  (mem_sign),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .mem_error (mem_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] size, input logic sign,
                        input logic [31:0] exp_rd, input logic exp_err);
      mem_we    = we;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_size  = size;
      mem_sign  = sign;
      mem_en    = 1'b1;
      sb.push_back({exp_err, exp_rd});
   endtask

   // Called at a negedge right after the request became visible.
   task automatic complete(input string tag, input int hold, input bit early_drop);
      int          cyc;
      logic [32:0] exp;
      cyc = 0;
      if (early_drop) begin
         @(negedge clk);
         cyc    = 1;
         mem_en = 1'b0;
      end
      while (!mem_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(LATENCY + 1));
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
         exp = 33'd0;
      end else begin
         exp = sb.pop_front();
      end
      chk({tag, "_rdata"}, mem_rdata, exp[31:0]);
      chk({tag, "_error"}, 32'(mem_error), 32'(exp[32]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_ready_hold"}, 32'(mem_ready), 32'd1);
         chk({tag, "_rdata_hold"}, mem_rdata, exp[31:0]);
      end
      mem_en = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_fall"}, 32'(mem_ready), 32'd0);
   endtask

   task automatic access(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] size, input logic sign,
                         input logic [31:0] exp_rd, input logic exp_err, input int hold,
                         input bit early_drop);
      @(negedge clk);
      drive(we, addr, wdata, size, sign, exp_rd, exp_err);
      complete(tag, hold, early_drop);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with a request pending
      rst = 1'b0;
      drive(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_error", 32'(mem_error), 32'd0);
      rst = 1'b1;
      complete("wr_word", 0, 1'b0);

      access("rd_word",   1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
      access("rd_b3_s",   1'b0, 32'h13, 32'h0, 4'b0001, 1'b1, 32'hFFFFFFDE, 1'b0, 0, 1'b0);
      access("rd_b3_z",   1'b0, 32'h13, 32'h0, 4'b0001, 1'b0, 32'h000000DE, 1'b0, 0, 1'b0);
      access("rd_h2_s",   1'b0, 32'h12, 32'h0, 4'b0011, 1'b1, 32'hFFFFDEAD, 1'b0, 0, 1'b0);
      access("rd_h0_z",   1'b0, 32'h10, 32'h0, 4'b0011, 1'b0, 32'h0000BEEF, 1'b0, 0, 1'b0);
      access("rd_b0_s",   1'b0, 32'h10, 32'h0, 4'b0001, 1'b1, 32'hFFFFFFEF, 1'b0, 0, 1'b0);
      access("wr_b1",     1'b1, 32'h11, 32'hFFFFFF55, 4'b0001, 1'b0, 32'h0, 1'b0, 0, 1'b0);
      access("rd_after_b", 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, 32'hDEAD55EF, 1'b0, 0, 1'b0);
      access("wr_h_mis",  1'b1, 32'h11, 32'h0000AAAA, 4'b0011, 1'b0, 32'h0, 1'b1, 0, 1'b0);
      access("rd_unchg",  1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, 32'hDEAD55EF, 1'b0, 0, 1'b0);
      access("rd_size5",  1'b0, 32'h10, 32'h0, 4'b0101, 1'b0, 32'h0, 1'b1, 0, 1'b0);
      access("rd_w_mis",  1'b0, 32'h12, 32'h0, 4'b1111, 1'b0, 32'h0, 1'b1, 0, 1'b0);
      access("wr_h2",     1'b1, 32'h12, 32'hFFFF1234, 4'b0011, 1'b0, 32'h0, 1'b0, 0, 1'b0);
      access("rd_alias",  1'b0, 32'h1010, 32'h0, 4'b1111, 1'b0, 32'h123455EF, 1'b0, 0, 1'b0);

      // Initiator abandons en during BUSY; write must still land
      access("wr_early",  1'b1, 32'h20, 32'hA5A5A5A5, 4'b1111, 1'b0, 32'h0, 1'b0, 0, 1'b1);
      access("rd_early",  1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, 32'hA5A5A5A5, 1'b0, 0, 1'b0);

      // Reset during BUSY drops the write
      @(negedge clk);
      mem_we    = 1'b1;
      mem_addr  = 32'h20;
      mem_wdata = 32'h0BADF00D;
      mem_size  = 4'b1111;
      mem_en    = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      mem_en = 1'b0;
      #1;
      chk("midrst_ready", 32'(mem_ready), 32'd0);
      chk("midrst_rdata", mem_rdata, 32'd0);
      chk("midrst_error", 32'(mem_error), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_idle", 32'(mem_ready), 32'd0);
      end
      access("rd_midrst", 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, 32'hA5A5A5A5, 1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
